// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and helpers for the two-master Wishbone memory
// arbiter (wb_mem_arbiter) and its watchdog (wb_arb_watchdog).
//   arb_state_e  - arbiter FSM states
//   GNT_*        - one-hot grant encodings (bit0 = master 0)
//   tie_winner() - which master wins when both request in IDLE
package wb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GNT0,
    GNT1,
    ERR0,
    ERR1
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Returns the master index (0/1) that wins a simultaneous request.
  // Fixed priority always favours master 1 (data); round-robin picks the
  // master that was not served last.
  function automatic logic tie_winner(input logic last, input logic fixed);
    return fixed ? 1'b1 : ~last;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: bus-timeout counter for the arbiter.
//   clk, rst   - clock, asynchronous active-high reset
//   clr_i      - hold the counter at zero (asserted outside a grant tenure)
//   en_i       - count one granted cycle
//   expired_o  - counter has reached TIMEOUT_CYCLES-1 (never set when
//                TIMEOUT_CYCLES is 0)
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates rather than wrapping, so a disabled watchdog cannot roll over.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) ? (cnt_q == LIMIT[CW-1:0]) : 1'b0;

endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master to one-slave Wishbone classic arbiter that lets
// the instruction (m0) and data (m1) buses share one memory port.
//   clk, rst              - clock, asynchronous active-high reset
//   m0_* / m1_*           - master ports: cyc/stb/we/sel/addr/wdata in,
//                           rdata/ack/err out
//   s_*                   - slave port: cyc/stb/we/sel/addr/wdata out,
//                           rdata/ack in
//   gnt                   - one-hot current grant (bit0 = m0), 00 when idle
// One transfer per tenure, then an IDLE bubble for re-arbitration. A stalled
// tenure is errored back to its master by the watchdog.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_ack,
  output logic [1:0]              gnt
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       req0, req1;
  logic       granted;
  logic       expired;

  assign req0    = m0_cyc & m0_stb;
  assign req1    = m1_cyc & m1_stb;
  assign granted = (state_q == GNT0) || (state_q == GNT1);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!granted),
    .en_i     (granted),
    .expired_o(expired)
  );

  // State register; also holds the last-served master for round-robin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic. Ack takes precedence over abort and timeout, so an
  // ack coinciding with watchdog expiry completes normally.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = tie_winner(last_q, FIXED_PRIORITY != 0) ? GNT1 : GNT0;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (s_ack || !m0_cyc) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (expired) begin
          state_d = ERR0;
        end
      end
      GNT1: begin
        if (s_ack || !m1_cyc) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (expired) begin
          state_d = ERR1;
        end
      end
      ERR0: begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
      ERR1: begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: everything is decoded from the registered state, so an
  // asynchronous reset forces all outputs idle immediately. Acks are gated
  // by the grant, which drops late acks arriving in IDLE or ERRx.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_addr   = '0;
    s_wdata  = '0;
    gnt      = GNT_NONE;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    unique case (state_q)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        gnt      = GNT_M0;
        m0_ack   = s_ack;
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        gnt      = GNT_M1;
        m1_ack   = s_ack;
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
      end
      ERR0:    m0_err = 1'b1;
      ERR1:    m1_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

  localparam logic [31:0] RD_KEY = 32'hDEADBEFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] s_rdata;
  logic        s_ack;
  logic        slv_ack_q;
  logic        force_ack;
  logic        ack_en;
  logic        use_fp;
  int          lat;
  int          slv_cnt;

  // Outputs of the round-robin (a_) and fixed-priority (b_) instances.
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
  logic [3:0]  a_s_sel, b_s_sel;
  logic [1:0]  a_gnt, b_gnt;

  // Outputs of the instance currently under test.
  logic [31:0] o_m0_rdata, o_m1_rdata, o_s_addr, o_s_wdata;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_s_cyc, o_s_stb, o_s_we;
  logic [3:0]  o_s_sel;
  logic [1:0]  o_gnt;

  assign o_m0_rdata = use_fp ? b_m0_rdata : a_m0_rdata;
  assign o_m1_rdata = use_fp ? b_m1_rdata : a_m1_rdata;
  assign o_s_addr   = use_fp ? b_s_addr   : a_s_addr;
  assign o_s_wdata  = use_fp ? b_s_wdata  : a_s_wdata;
  assign o_m0_ack   = use_fp ? b_m0_ack   : a_m0_ack;
  assign o_m0_err   = use_fp ? b_m0_err   : a_m0_err;
  assign o_m1_ack   = use_fp ? b_m1_ack   : a_m1_ack;
  assign o_m1_err   = use_fp ? b_m1_err   : a_m1_err;
  assign o_s_cyc    = use_fp ? b_s_cyc    : a_s_cyc;
  assign o_s_stb    = use_fp ? b_s_stb    : a_s_stb;
  assign o_s_we     = use_fp ? b_s_we     : a_s_we;
  assign o_s_sel    = use_fp ? b_s_sel    : a_s_sel;
  assign o_gnt      = use_fp ? b_gnt      : a_gnt;

  assign s_ack = slv_ack_q | force_ack;

  always #5 clk = ~clk;

  wb_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .FIXED_PRIORITY(0)
  ) dut_rr (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(a_m0_rdata),
    .m0_ack(a_m0_ack), .m0_err(a_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(a_m1_rdata),
    .m1_ack(a_m1_ack), .m1_err(a_m1_err),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we), .s_sel(a_s_sel),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
    .gnt(a_gnt)
  );

  wb_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(64), .FIXED_PRIORITY(1)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(b_m0_rdata),
    .m0_ack(b_m0_ack), .m0_err(b_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(b_m1_rdata),
    .m1_ack(b_m1_ack), .m1_err(b_m1_err),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_sel(b_s_sel),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
    .gnt(b_gnt)
  );

  // Slave responder: acks `lat` cycles after it first sees a request and
  // returns read data derived from the address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_ack_q <= 1'b0;
      slv_cnt   <= 0;
      s_rdata   <= '0;
    end else if (slv_ack_q) begin
      slv_ack_q <= 1'b0;
      slv_cnt   <= 0;
    end else if (ack_en && o_s_cyc && o_s_stb) begin
      if (slv_cnt == lat - 1) begin
        slv_ack_q <= 1'b1;
        s_rdata   <= o_s_addr ^ RD_KEY;
      end else begin
        slv_cnt <= slv_cnt + 1;
      end
    end else begin
      slv_cnt <= 0;
    end
  end

  typedef struct {
    logic [1:0]  who;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_addr = '0; m0_wdata = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_addr = '0; m1_wdata = '0;
  endtask

  // Leaves reset released at a falling edge; the caller drives requests next.
  task automatic do_reset(input logic fp);
    rst = 1'b1;
    idle_masters();
    force_ack = 1'b0;
    use_fp = fp;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Both masters issue reads back-to-back; each ack is matched against the
  // scoreboard queue filled by the caller.
  task automatic run_traffic(input int n0, input int n1, input int budget);
    int left0 = n0;
    int left1 = n1;
    int k0 = 0;
    int k1 = 0;
    exp_t e;
    m0_cyc = (left0 > 0); m0_stb = (left0 > 0); m0_sel = 4'hF; m0_addr = 32'h1000;
    m1_cyc = (left1 > 0); m1_stb = (left1 > 0); m1_sel = 4'hF; m1_addr = 32'h2000;
    for (int c = 0; c < budget && (left0 > 0 || left1 > 0); c++) begin
      @(negedge clk);
      if (o_m0_ack || o_m1_ack) begin
        if (exp_q.size() == 0) begin
          check("traffic_unexpected_ack", {o_m1_ack, o_m0_ack}, 0);
        end else begin
          e = exp_q.pop_front();
          check("traffic_who", {o_m1_ack, o_m0_ack}, e.who);
          check("traffic_gnt", o_gnt, {o_m1_ack, o_m0_ack});
          check("traffic_rdata", o_m0_ack ? o_m0_rdata : o_m1_rdata, e.rdata);
        end
        if (o_m0_ack) begin
          left0--; k0++;
          m0_addr = 32'h1000 + 32'(k0 * 4);
          if (left0 == 0) begin m0_cyc = 0; m0_stb = 0; end
        end
        if (o_m1_ack) begin
          left1--; k1++;
          m1_addr = 32'h2000 + 32'(k1 * 4);
          if (left1 == 0) begin m1_cyc = 0; m1_stb = 0; end
        end
      end
    end
    check("traffic_remaining", 64'(left0 + left1), 0);
    check("traffic_queue_empty", 64'(exp_q.size()), 0);
    idle_masters();
  endtask

  initial begin
    ack_en = 1'b1;
    lat = 2;
    do_reset(1'b0);

    // Reset state.
    check("rst_ctrl", {o_gnt, o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, 0);
    check("rst_addr_data", {o_s_addr, o_s_wdata}, 0);
    check("rst_rdata", {o_m0_rdata, o_m1_rdata}, 0);

    // Single m0 read, slave latency 2.
    m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF; m0_addr = 32'h0000_0010;
    @(negedge clk);
    check("rd_c1_cyc_gnt", {o_s_cyc, o_s_stb, o_gnt}, {1'b1, 1'b1, 2'b01});
    check("rd_c1_addr", o_s_addr, 32'h10);
    check("rd_c1_ack", o_m0_ack, 0);
    @(negedge clk);
    check("rd_c2_ack", o_m0_ack, 0);
    @(negedge clk);
    check("rd_c3_ack", {o_m1_ack, o_m0_ack}, 2'b01);
    check("rd_c3_rdata", o_m0_rdata, 32'hDEADBEEF);
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    check("rd_c4_idle", {o_gnt, o_s_cyc}, 0);

    // Round-robin: both masters, 4 transfers each, strict alternation.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{2'b01, (32'h1000 + 32'(i * 4)) ^ RD_KEY});
      exp_q.push_back('{2'b10, (32'h2000 + 32'(i * 4)) ^ RD_KEY});
    end
    run_traffic(4, 4, 200);

    // Fixed priority: m1 wins every tie, m0 only after m1 stops.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back('{2'b10, (32'h2000 + 32'(i * 4)) ^ RD_KEY});
    for (int i = 0; i < 2; i++) exp_q.push_back('{2'b01, (32'h1000 + 32'(i * 4)) ^ RD_KEY});
    run_traffic(2, 3, 200);

    // Watchdog: m1 write never acked, TIMEOUT_CYCLES = 8.
    do_reset(1'b0);
    ack_en = 1'b0;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF;
    m1_addr = 32'h100; m1_wdata = 32'h12345678;
    @(negedge clk);
    check("to_c1_gnt_we", {o_gnt, o_s_we}, {2'b10, 1'b1});
    check("to_c1_addr_data", {o_s_addr, o_s_wdata}, {32'h100, 32'h12345678});
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      check("to_wait_no_err", {o_m1_err, o_gnt}, {1'b0, 2'b10});
    end
    @(negedge clk);
    check("to_err_pulse", {o_m1_err, o_m0_err, o_m1_ack}, 3'b100);
    check("to_err_bus_idle", {o_s_cyc, o_s_stb, o_gnt}, 0);
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    force_ack = 1'b1;
    #1;
    check("to_late_ack_in_err", {o_m1_ack, o_m0_ack}, 0);
    force_ack = 1'b0;
    @(negedge clk);
    check("to_err_one_cycle", {o_m1_err, o_gnt}, 0);
    force_ack = 1'b1;
    #1;
    check("to_late_ack_in_idle", {o_m1_ack, o_m0_ack}, 0);
    force_ack = 1'b0;

    // Ack on the same cycle the watchdog expires: ack wins.
    do_reset(1'b0);
    m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF; m0_addr = 32'h20;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 force_ack = 1'b1;
    @(negedge clk);
    check("race_ack_wins", {o_m0_ack, o_m0_err}, 2'b10);
    m0_cyc = 0; m0_stb = 0;
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    check("race_no_err_after", {o_m0_err, o_gnt}, 0);

    // Asynchronous reset mid-transfer, then first tie goes to m0.
    do_reset(1'b0);
    m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF; m0_addr = 32'h40;
    @(negedge clk);
    check("arst_pre_cyc", o_s_cyc, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_outputs", {o_s_cyc, o_s_stb, o_gnt, o_m0_ack}, 0);
    force_ack = 1'b1;
    #1;
    check("arst_ack_blocked", o_m0_ack, 0);
    force_ack = 1'b0;
    m1_cyc = 1; m1_stb = 1; m1_sel = 4'hF; m1_addr = 32'h80;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_first_tie_m0", o_gnt, 2'b01);
    idle_masters();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master to one-slave Wishbone classic arbiter.
- Lets a Harvard-style core wrapper share the single Controller memory port (core_cyc/stb/we/sel/addr/data/ack) between its instruction and data buses when ENABLE_SECOND_MEMORY is not defined.
- Sits between the core-side bus adapters and the Controller.
- Provides round-robin or fixed-priority arbitration, tenure held until acknowledge, and a bus-timeout watchdog that returns an error to a master whose transaction stalls.

Parameters:
- ADDR_WIDTH, 32, address width of masters and slave.
- DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, cycles a granted transaction may wait for s_ack before it is errored. 0 disables the watchdog.
- FIXED_PRIORITY, 0. 0 = round-robin; 1 = m1 (data) always wins ties.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 (instruction) control
- m0_sel  in  DATA_WIDTH/8  byte selects
- m0_addr  in  ADDR_WIDTH  address
- m0_wdata  in  DATA_WIDTH  write data
- m0_rdata  out  DATA_WIDTH  read data
- m0_ack  out  1  acknowledge
- m0_err  out  1  timeout error
- m1_*  same set as m0_*  master 1 (data)
- s_cyc, s_stb, s_we  out  1 each  slave control
- s_sel  out  DATA_WIDTH/8  byte selects
- s_addr  out  ADDR_WIDTH  address
- s_wdata  out  DATA_WIDTH  write data
- s_rdata  in  DATA_WIDTH  read data
- s_ack  in  1  acknowledge
- gnt  out  2  one-hot current grant (bit0 = m0); 00 when idle

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - State IDLE; last-granted pointer = 1, so m0 wins the first tie.
  - Watchdog counter = 0.
  - All s_* outputs 0; m*_ack = 0, m*_err = 0, gnt = 00, m*_rdata = 0.
- Request definition: reqX = mX_cyc & mX_stb.
- States: IDLE, GNT0, GNT1, ERR0, ERR1. The state register is the only place grant is stored.
- IDLE:
  - No request: remain in IDLE.
  - Single request: go to its GNTx.
  - Both requesting, FIXED_PRIORITY=1: go to GNT1.
  - Both requesting, round-robin: grant the master not equal to last.
  - All slave outputs are 0 in IDLE.
  - Latency: request sampled at edge N; s_cyc/s_stb high during cycle N+1.
- GNTx:
  - s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata are combinationally muxed from master x. gnt is one-hot x.
  - mx_ack = s_ack. The other master's ack and err are 0.
  - m0_rdata and m1_rdata both carry s_rdata (broadcast; only the acked master may use it).
  - On s_ack: next state IDLE, last <= x. Each tenure is one transfer, followed by one idle bubble; back-to-back throughput is one transfer per (slave latency + 2) cycles.
  - On mx_cyc low before ack (abort): next state IDLE, last <= x. The slave sees cyc drop the same cycle.
- Watchdog:
  - Counter clears on entry to GNTx and increments each GNTx cycle.
  - If TIMEOUT_CYCLES != 0, the counter equals TIMEOUT_CYCLES-1, and s_ack = 0: go to ERRx.
  - s_ack and the timeout condition in the same cycle: the ack wins and no error is raised.
  - Counter width is $clog2(TIMEOUT_CYCLES+1) and must never wrap.
- ERRx:
  - One cycle with s_cyc = s_stb = 0, mx_err = 1, mx_ack = 0, gnt = 00.
  - Then IDLE with last <= x.
  - A late s_ack arriving in ERRx or IDLE is ignored and is not forwarded to any master.
- The non-granted master's request is held off (no ack) until arbitration in IDLE. The arbiter requires masters to keep cyc/stb/address stable while waiting.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous). The slave sees the cycle aborted.

Decomposition:
- Shared package wb_arb_pkg:
  - state enum (IDLE, GNT0, GNT1, ERR0, ERR1)
  - GNT_NONE/GNT_M0/GNT_M1 one-hot constants
  - function tie_winner(last, fixed)
- Sub-module wb_arb_watchdog holds the counter, the clear/enable inputs and the expired output; it is parameterised by TIMEOUT_CYCLES.
- The mux and FSM stay in the top module.

Test Plan:
- Reset, then m0 read @0x00000010 with slave acking after 2 cycles → s_cyc high at cycle 1; m0_ack at cycle 3 with m0_rdata = s_rdata = 0xDEADBEEF; gnt returns to 00 at cycle 4.
- m0 and m1 request simultaneously, round-robin, 4 back-to-back transfers each → grants alternate m0, m1, m0, m1…; m1 never acked while gnt = 01.
- FIXED_PRIORITY=1, both request continuously → m1 wins every arbitration; m0 is served only when m1 idles.
- TIMEOUT_CYCLES=8, slave never acks m1 write 0x12345678 @0x100 → m1_err high exactly one cycle, 8 cycles after grant; s_cyc low during ERR; a later s_ack pulse is ignored.
- s_ack arrives on the same cycle the watchdog expires → m_ack = 1 and m_err = 0.
- rst pulsed while GNT0 with s_cyc high → s_cyc, gnt and m0_ack read 0 without waiting for a clock edge; the first tie after reset goes to m0.
